// File: rtl/sdram_pattern_bist.sv
// sdram_pattern_bist: SDRAM pattern self-test engine for the controller's sys_* port.
// It writes a 16-bit Galois LFSR sequence over an inclusive word range, then reads
// the range back and compares it. It reports the mismatch count, the first failing
// word and any controller timeout.
// Build option SDRAM_BIST_INVERT_PASS_EN adds a second write/read pass that uses the
// inverted pattern.
module sdram_pattern_bist #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [15:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              timeout,
  output logic [ADDR_W-1:0] sys_addr,
  output logic [DATA_W-1:0] sys_data_to_sdram,
  input  logic [DATA_W-1:0] sys_data_from_sdram,
  input  logic              sys_data_from_sdram_valid,
  input  logic              sys_write_done,
  output logic              sys_write_rq,
  output logic              sys_read_rq
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_REQ = 3'd1;
  localparam logic [2:0] WR_GAP = 3'd2;
  localparam logic [2:0] RD_REQ = 3'd3;
  localparam logic [2:0] RD_GAP = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam int          WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED_ZERO = 16'hACE1;

  logic [2:0]        state;
  logic [ADDR_W:0]   addr;      // one spare bit so an all-ones end address never wraps to 0
  logic [ADDR_W:0]   start_r;
  logic [ADDR_W:0]   end_r;
  logic [ADDR_W:0]   addr_inc;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [15:0]       seed_r;
  logic [15:0]       seed_eff;
  logic [WD_W-1:0]   wd_cnt;
  logic              range_ok;  // 0 when end_addr < start_addr: such a run can never pass
  logic              inv;       // data of the current pass is the inverted pattern
  logic [DATA_W-1:0] exp_data;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [15:0] v, input logic invert);
    pattern = DATA_W'(invert ? ~v : v);
  endfunction

  assign seed_eff = (seed == 16'h0000) ? SEED_ZERO : seed;
  assign addr_inc = addr + 1'b1;
  assign lfsr_nxt = lfsr_step(lfsr);
  assign exp_data = pattern(lfsr, inv);

`ifdef SDRAM_BIST_INVERT_PASS_EN
  // Pass select: cleared at start, set once the plain-pattern read pass has completed
  always_ff @(posedge clk) begin
    if (reset) begin
      inv <= 1'b0;
    end else if (state == IDLE && start) begin
      inv <= 1'b0;
    end else if (state == RD_GAP && addr == end_r) begin
      inv <= 1'b1;
    end
  end
`else
  assign inv = 1'b0;
`endif

  // Sequencer: request handshakes, address/LFSR advance, compare, watchdog, result
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      err_count         <= '0;
      first_err_addr    <= '0;
      first_err_exp     <= '0;
      first_err_got     <= '0;
      timeout           <= 1'b0;
      sys_addr          <= '0;
      sys_data_to_sdram <= '0;
      sys_write_rq      <= 1'b0;
      sys_read_rq       <= 1'b0;
      wd_cnt            <= '0;
      range_ok          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            start_r        <= {1'b0, start_addr};
            end_r          <= {1'b0, end_addr};
            addr           <= {1'b0, start_addr};
            seed_r         <= seed_eff;
            lfsr           <= seed_eff;
            if (end_addr < start_addr) begin
              range_ok <= 1'b0;
              state    <= FINISH;
            end else begin
              range_ok          <= 1'b1;
              sys_write_rq      <= 1'b1;
              sys_addr          <= start_addr;
              sys_data_to_sdram <= pattern(seed_eff, 1'b0);
              wd_cnt            <= '0;
              state             <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (sys_write_done) begin
            sys_write_rq <= 1'b0;
            state        <= WR_GAP;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            sys_write_rq <= 1'b0;
            timeout      <= 1'b1;
            state        <= FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WR_GAP: begin
          wd_cnt <= '0;
          if (addr == end_r) begin
            addr        <= start_r;
            lfsr        <= seed_r;
            sys_addr    <= start_r[ADDR_W-1:0];
            sys_read_rq <= 1'b1;
            state       <= RD_REQ;
          end else begin
            addr              <= addr_inc;
            lfsr              <= lfsr_nxt;
            sys_addr          <= addr_inc[ADDR_W-1:0];
            sys_data_to_sdram <= pattern(lfsr_nxt, inv);
            sys_write_rq      <= 1'b1;
            state             <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (sys_data_from_sdram_valid) begin
            if (sys_data_from_sdram != exp_data) begin
              err_count <= sat_inc(err_count);
              if (err_count == 16'h0000) begin
                first_err_addr <= addr[ADDR_W-1:0];
                first_err_exp  <= exp_data;
                first_err_got  <= sys_data_from_sdram;
              end
            end
            sys_read_rq <= 1'b0;
            state       <= RD_GAP;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            sys_read_rq <= 1'b0;
            timeout     <= 1'b1;
            state       <= FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RD_GAP: begin
          wd_cnt <= '0;
          if (addr == end_r) begin
`ifdef SDRAM_BIST_INVERT_PASS_EN
            if (!inv) begin
              addr              <= start_r;
              lfsr              <= seed_r;
              sys_addr          <= start_r[ADDR_W-1:0];
              sys_data_to_sdram <= pattern(seed_r, 1'b1);
              sys_write_rq      <= 1'b1;
              state             <= WR_REQ;
            end else begin
              state <= FINISH;
            end
`else
            state <= FINISH;
`endif
          end else begin
            addr        <= addr_inc;
            lfsr        <= lfsr_nxt;
            sys_addr    <= addr_inc[ADDR_W-1:0];
            sys_read_rq <= 1'b1;
            state       <= RD_REQ;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= range_ok && (err_count == 16'h0000) && !timeout;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_bist.sv
// Bench for sdram_pattern_bist. It uses an ideal controller model with a 3-cycle
// strobe, backed by a word memory. Each run pushes its expected writes and its
// expected result into queues. The controller model and the done monitor pop those
// queues and compare.
module tb_sdram_pattern_bist;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [15:0]       seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_exp;
  logic [DATA_W-1:0] first_err_got;
  logic              timeout;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_data_to_sdram;
  logic [DATA_W-1:0] sys_data_from_sdram;
  logic              sys_data_from_sdram_valid;
  logic              sys_write_done;
  logic              sys_write_rq;
  logic              sys_read_rq;

  sdram_pattern_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .timeout(timeout), .sys_addr(sys_addr),
    .sys_data_to_sdram(sys_data_to_sdram), .sys_data_from_sdram(sys_data_from_sdram),
    .sys_data_from_sdram_valid(sys_data_from_sdram_valid), .sys_write_done(sys_write_done),
    .sys_write_rq(sys_write_rq), .sys_read_rq(sys_read_rq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  typedef struct {
    logic              pass;
    logic [15:0]       err;
    logic [ADDR_W-1:0] fa;
    logic [15:0]       fe;
    logic [15:0]       fg;
    logic              to;
    int                nwr;
    int                nrd;
    int                lat;   // start-to-done cycles, -1 = not checked
    int                rdhi;  // length of the last read request, -1 = not checked
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int n_wr = 0, n_rd = 0, n_tz = 0, last_rd_len = 0;
  int base_wr = 0, base_rd = 0, base_tz = 0;

  logic                corrupt_en = 1'b0;
  logic [ADDR_W-1:0]   corrupt_addr = '0;
  logic                drop_rd = 1'b0;
  logic [15:0]         mem [logic [ADDR_W-1:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Ideal controller: strobe 3 cycles into each request, memory-backed reads
  initial begin
    int wcnt = 0, rcnt = 0, rlen = 0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    wr_t e;
    sys_write_done = 1'b0;
    sys_data_from_sdram_valid = 1'b0;
    sys_data_from_sdram = '0;
    forever begin
      @(negedge clk);
      sys_write_done = 1'b0;
      sys_data_from_sdram_valid = 1'b0;
      if (reset) begin
        wcnt = 0; rcnt = 0; rlen = 0; prev_wr = 1'b0; prev_rd = 1'b0;
      end else begin
        if (sys_write_rq && !prev_wr) begin n_wr++; if (sys_addr == '0) n_tz++; end
        if (sys_read_rq && !prev_rd) begin n_rd++; if (sys_addr == '0) n_tz++; end
        prev_wr = sys_write_rq;
        prev_rd = sys_read_rq;
        if (sys_write_rq) begin
          wcnt++;
          if (wcnt == 3) begin
            sys_write_done = 1'b1;
            mem[sys_addr] = sys_data_to_sdram;
            if (wr_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
            else begin
              e = wr_q.pop_front();
              chk("wr_addr", 32'(sys_addr), 32'(e.addr));
              chk("wr_data", 32'(sys_data_to_sdram), 32'(e.data));
            end
          end
        end else wcnt = 0;
        if (sys_read_rq) begin
          rcnt++; rlen++;
          if (rcnt == 3 && !drop_rd) begin
            sys_data_from_sdram_valid = 1'b1;
            sys_data_from_sdram = mem[sys_addr] ^
              ((corrupt_en && sys_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
          end
        end else begin
          rcnt = 0;
          if (rlen != 0) last_rd_len = rlen;
          rlen = 0;
        end
      end
    end
  end

  // Result monitor: every done pulse is matched against the oldest expected result
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (res_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          chk("pass", 32'(pass), 32'(r.pass));
          chk("err_count", 32'(err_count), 32'(r.err));
          chk("first_err_addr", 32'(first_err_addr), 32'(r.fa));
          chk("first_err_exp", 32'(first_err_exp), 32'(r.fe));
          chk("first_err_got", 32'(first_err_got), 32'(r.fg));
          chk("timeout", 32'(timeout), 32'(r.to));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("write_count", 32'(n_wr - base_wr), 32'(r.nwr));
          chk("read_count", 32'(n_rd - base_rd), 32'(r.nrd));
          chk("addr0_touched", 32'(n_tz - base_tz), 32'd0);
          if (r.lat >= 0) chk("done_latency", 32'(cyc - start_cyc), 32'(r.lat));
          if (r.rdhi >= 0) chk("rd_rq_high_len", 32'(last_rd_len), 32'(r.rdhi));
        end
        done_cnt++;
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_res(input logic p, input logic [15:0] er, input logic [ADDR_W-1:0] fa,
                          input logic [15:0] fe, input logic [15:0] fg, input logic to,
                          input int nwr, input int nrd, input int lat, input int rdhi);
    res_t r;
    r.pass = p; r.err = er; r.fa = fa; r.fe = fe; r.fg = fg; r.to = to;
    r.nwr = nwr; r.nrd = nrd; r.lat = lat; r.rdhi = rdhi;
    res_q.push_back(r);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                          input logic [15:0] sd);
    @(negedge clk);
    start_addr = sa; end_addr = ea; seed = sd; start = 1'b1;
    start_cyc = cyc; base_wr = n_wr; base_rd = n_rd; base_tz = n_tz;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while (done_cnt < target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt < target) chk("run_completion", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Expected LFSR sequences: ACE1 -> E270 -> 7138 -> 389C ; 1234 -> 091A
  task automatic push_std_writes();
    push_wr(22'h10, 16'hACE1);
    push_wr(22'h11, 16'hE270);
    push_wr(22'h12, 16'h7138);
    push_wr(22'h13, 16'h389C);
  endtask

  // Directed stimulus sequence
  initial begin
    int i;
    reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_pass_to", 32'({done, pass, timeout}), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_rq", 32'({sys_write_rq, sys_read_rq}), 32'd0);
    chk("rst_first_err", 32'(first_err_addr) | 32'(first_err_exp) | 32'(first_err_got), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // clean 4-word run, seed 0 becomes ACE1
    push_std_writes();
    push_res(1'b1, 16'd0, '0, 16'h0, 16'h0, 1'b0, 4, 4, -1, -1);
    do_start(22'h10, 22'h13, 16'h0000);
    @(negedge clk);
    chk("busy_running", 32'(busy), 32'd1);
    wait_done(1);
    chk("done_one_cycle", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("pass_held", 32'(pass), 32'd1);

    // same run with the read at 0x12 corrupted by XOR 1
    corrupt_en = 1'b1; corrupt_addr = 22'h12;
    push_std_writes();
    push_res(1'b0, 16'd1, 22'h12, 16'h7138, 16'h7139, 1'b0, 4, 4, -1, -1);
    do_start(22'h10, 22'h13, 16'h0000);
    wait_done(2);
    corrupt_en = 1'b0;

    // single-word run whose read is never answered
    drop_rd = 1'b1;
    push_wr(22'h20, 16'h0001);
    push_res(1'b0, 16'd0, '0, 16'h0, 16'h0, 1'b1, 1, 1, -1, TIMEOUT);
    do_start(22'h20, 22'h20, 16'h0001);
    wait_done(3);
    drop_rd = 1'b0;

    // top of the address space: 2 words, must not wrap to 0
    push_wr(22'h3FFFFE, 16'h1234);
    push_wr(22'h3FFFFF, 16'h091A);
    push_res(1'b1, 16'd0, '0, 16'h0, 16'h0, 1'b0, 2, 2, -1, -1);
    do_start(22'h3FFFFE, 22'h3FFFFF, 16'h1234);
    wait_done(4);

    // empty range: no requests, done two cycles after start, fail
    push_res(1'b0, 16'd0, '0, 16'h0, 16'h0, 1'b0, 0, 0, 2, -1);
    do_start(22'h5, 22'h4, 16'hBEEF);
    wait_done(5);

    // reset while a write request is pending
    push_std_writes();
    do_start(22'h10, 22'h13, 16'h0000);
    i = 0;
    while (!sys_write_rq && i < 50) begin @(negedge clk); i++; end
    chk("wr_rq_seen", 32'(sys_write_rq), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr_rq", 32'(sys_write_rq), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wr_q.delete();
    repeat (2) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd5);
    push_std_writes();
    push_res(1'b1, 16'd0, '0, 16'h0, 16'h0, 1'b0, 4, 4, -1, -1);
    do_start(22'h10, 22'h13, 16'h0000);
    wait_done(6);

    chk("queues_drained", 32'(res_q.size() + wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  // Absolute time limit
  initial begin
    #500000;
    $display("FAIL global_time_limit: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sdram_pattern_bist.md
Name: sdram_pattern_bist

Overview:
Self-contained SDRAM built-in self-test engine that drives the sys_* request interface of the SDRAM controller.
- On start, it writes a 16-bit LFSR pattern over an inclusive address range.
- It then reads the range back, compares every word and records the error count plus the first failing word.
- It sits beside the UART command tester, directly upstream of the SDRAM controller, in the 100 MHz clock domain; the tester launches runs and reports results.

Parameters:
ADDR_W, 22, word address width of sys_addr
DATA_W, 16, data width of the SDRAM word bus
TIMEOUT, 1023, max cycles a request may wait for write_done/data_valid before the run aborts

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; launches a run when idle
start_addr  in  ADDR_W  first word address (inclusive)
end_addr  in  ADDR_W  last word address (inclusive)
seed  in  16  LFSR seed; 0 is replaced by 16'hACE1
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at run end
pass  out  1  1 = no mismatches and no timeout; held until the next start
err_count  out  16  mismatch count, saturates at 16'hFFFF
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_exp  out  DATA_W  expected data at the first mismatch
first_err_got  out  DATA_W  read data at the first mismatch
timeout  out  1  run aborted on a controller timeout
sys_addr  out  ADDR_W  to controller
sys_data_to_sdram  out  DATA_W  to controller
sys_data_from_sdram  in  DATA_W  from controller
sys_data_from_sdram_valid  in  1  read data strobe
sys_write_done  in  1  write completion strobe
sys_write_rq  out  1  write request, level
sys_read_rq  out  1  read request, level

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. first_err_* = 0. State = IDLE.
- LFSR: Galois, right shift, mask 16'hB400. Next value = (v>>1) ^ (v[0] ? 16'hB400 : 0). One step per word.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH.
- IDLE:
  - start accepted → busy=1; clear err_count, first_err_*, timeout, pass.
  - Load addr=start_addr and lfsr=seed (or ACE1 if seed is 0). Go to WR_REQ.
  - start while busy is ignored.
- WR_REQ:
  - sys_write_rq=1, sys_addr=addr, sys_data_to_sdram=lfsr. All three are held stable until sys_write_done is sampled high.
  - Then drop rq on the next edge and go to WR_GAP. Rq stays low for at least 1 cycle between requests.
- WR_GAP:
  - If addr==end_addr: addr=start_addr, reload lfsr from seed, go to RD_REQ.
  - Otherwise: addr+1, lfsr step, go to WR_REQ.
- RD_REQ:
  - sys_read_rq=1 with sys_addr held.
  - On sys_data_from_sdram_valid: compare the data with lfsr.
  - On mismatch: err_count+1 (saturating). If it is the first mismatch, capture addr, lfsr and the read data.
  - Drop rq and go to RD_GAP.
- RD_GAP: same advance rule as WR_GAP. At end_addr go to FINISH.
- FINISH:
  - done=1 for one cycle; busy=0.
  - pass = (err_count==0 && !timeout).
  - Return to IDLE.
- Address counter is ADDR_W+1 bits internally. end_addr = all-ones completes without wrapping to 0.
- Range rules:
  - start_addr==end_addr: single-word run.
  - end_addr<start_addr: no requests issued. done pulses 2 cycles after start, pass=0, err_count=0.
- Watchdog:
  - Cycle counter cleared on entry to WR_REQ/RD_REQ.
  - When it reaches TIMEOUT without a strobe: drop rq, set timeout=1, go to FINISH (pass=0).
  - A strobe in the same cycle as expiry wins; no timeout is flagged.
- Spurious strobes outside WR_REQ/RD_REQ are ignored.
- Reset mid-run: on the next edge rq drops to 0 and all outputs return to reset values. No done pulse.

Optional Feature:
SDRAM_BIST_INVERT_PASS_EN
- Defined: after the read-compare pass, a second write+read pass runs over the same range with data = ~lfsr (same seed sequence).
  - The second pass's errors accumulate into the same err_count.
  - first_err_* is captured only if still empty.
  - done only after pass 2.
- Undefined: single pass only; no extra logic.

Test Plan:
- Ideal controller model (write_done/valid 3 cycles after rq), start_addr=0x10, end_addr=0x13, seed=0 → writes 0xACE1, 0xE270, then the next LFSR values to 0x10..0x13; 8 requests total; done, pass=1, err_count=0.
- Same run; model corrupts the read at 0x12 by XOR 0x0001 → err_count=1, first_err_addr=0x12, first_err_got = exp^1, pass=0.
- Model never asserts valid on the first read, TIMEOUT=1023 → rq drops after 1023 cycles, timeout=1, pass=0, done pulse.
- end_addr=0x3FFFFF, start_addr=0x3FFFFE → exactly 2 writes and 2 reads; no access to 0x000000.
- start_addr=5, end_addr=4 → no rq ever asserted; done 2 cycles after start, pass=0.
- Assert reset during WR_REQ → sys_write_rq=0 and busy=0 next cycle; a new start runs cleanly from start_addr.
